// File: rtl/spawn_pkg.sv
// Shared types and constants for the spawn scheduler and its helpers.
//   spawn_state_t : scheduler FSM states
//   spawn_owner_t : which requester owns the current placement
//   spawn_cell_t  : packed playfield coordinate (column x, row y)
//   cellInRange() : true when a cell lies inside the 14x10 playfield (1-based)
package spawn_pkg;

    localparam int unsigned GRID_W  = 14;
    localparam int unsigned GRID_H  = 10;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned LFSR_W  = 8;

    // Feedback taps 8,6,5,4 expressed as a bit mask over lfsr[7:0]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        CHECK,
        COMMIT
    } spawn_state_t;

    typedef enum logic {
        OWN_APPLE,
        OWN_OBS
    } spawn_owner_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } spawn_cell_t;

    function automatic logic cellInRange(input spawn_cell_t c);
        return (c.x >= COORD_W'(1)) && (c.x <= COORD_W'(GRID_W)) &&
               (c.y >= COORD_W'(1)) && (c.y <= COORD_W'(GRID_H));
    endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4, shifting left).
// Advances every clock; only nRst reloads the seed. SEED must be nonzero,
// otherwise the register locks up at zero.
//   clk  : clock
//   nRst : asynchronous active-low reset, loads SEED
//   lfsr : current register value
module spawn_lfsr
    import spawn_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              nRst,
    output logic [LFSR_W-1:0] lfsr
);

    // Shift left, feedback parity of the tapped bits into bit 0
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/spawn_scheduler.sv
// Arbitrates one random-coordinate source and one external occupancy checker
// between apple respawn and obstacle spawn requests. Candidates are drawn
// from the LFSR, held for the checker, and committed with a one-cycle write
// pulse to the winning requester; a request is dropped with a fail pulse
// after MAX_RETRIES rejected candidates.
// Build option: define SPAWN_RR_EN for round-robin grant on ties
// (default: apple always wins ties).
// Ports:
//   clk, nRst          : clock, asynchronous active-low reset
//   s_reset            : synchronous soft reset (new game)
//   apple_req, obs_req : request pulses
//   chk_valid, cand_x/y: candidate presented to the checker
//   chk_done, chk_ok   : checker verdict
//   apple_we, obs_we   : one-cycle commit pulses, with place_x/y
//   busy               : FSM not idle
//   fail               : one-cycle pulse, request dropped
//   obs_pending        : queued obstacle requests
module spawn_scheduler
    import spawn_pkg::*;
#(
    parameter int unsigned       MAX_RETRIES   = 15,
    parameter int unsigned       OBS_QUEUE_MAX = 3,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 8'hA5
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               s_reset,
    input  logic               apple_req,
    input  logic               obs_req,
    output logic               chk_valid,
    output logic [COORD_W-1:0] cand_x,
    output logic [COORD_W-1:0] cand_y,
    input  logic               chk_done,
    input  logic               chk_ok,
    output logic               apple_we,
    output logic               obs_we,
    output logic [COORD_W-1:0] place_x,
    output logic [COORD_W-1:0] place_y,
    output logic               busy,
    output logic               fail,
    output logic [2:0]         obs_pending
);

    localparam int unsigned RETRY_W = 8;
    localparam int unsigned PEND_W  = 3;

    spawn_state_t       state;
    spawn_state_t       stateNext;
    spawn_owner_t       owner;
    spawn_owner_t       ownerNext;
    logic [RETRY_W-1:0] retryCnt;
    logic [RETRY_W-1:0] retryNext;
    logic               applePending;
    logic               applePendingNext;
    logic [PEND_W-1:0]  obsPendingNext;
    spawn_cell_t        cand;
    spawn_cell_t        candNext;
    spawn_cell_t        place;
    spawn_cell_t        placeNext;
    spawn_cell_t        sample;
    logic               appleWeNext;
    logic               obsWeNext;
    logic               failNext;
    logic               grantApple;
    logic               grantObs;
    logic               appleWinsTie;
    logic               retryLast;
    logic [LFSR_W-1:0]  lfsrValue;

    spawn_lfsr #(
        .SEED (LFSR_SEED)
    ) uLfsr (
        .clk  (clk),
        .nRst (nRst),
        .lfsr (lfsrValue)
    );

    // Low nibble is the column, high nibble the row
    assign sample    = {lfsrValue[3:0], lfsrValue[7:4]};
    assign retryLast = (retryCnt == RETRY_W'(MAX_RETRIES - 1));

`ifdef SPAWN_RR_EN
    // Last-granted requester; starts as obstacle so apple wins the first tie
    spawn_owner_t lastGrant;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            lastGrant <= OWN_OBS;
        end else if (grantApple) begin
            lastGrant <= OWN_APPLE;
        end else if (grantObs) begin
            lastGrant <= OWN_OBS;
        end
    end

    assign appleWinsTie = (lastGrant == OWN_OBS);
`else
    assign appleWinsTie = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        stateNext   = state;
        ownerNext   = owner;
        retryNext   = retryCnt;
        candNext    = cand;
        placeNext   = place;
        appleWeNext = 1'b0;
        obsWeNext   = 1'b0;
        failNext    = 1'b0;
        grantApple  = 1'b0;
        grantObs    = 1'b0;

        case (state)
            IDLE: begin
                if (applePending || (obs_pending != '0)) begin
                    retryNext = '0;
                    stateNext = GEN;
                    if (applePending && ((obs_pending == '0) || appleWinsTie)) begin
                        ownerNext  = OWN_APPLE;
                        grantApple = 1'b1;
                    end else begin
                        ownerNext = OWN_OBS;
                        grantObs  = 1'b1;
                    end
                end
            end
            GEN: begin
                if (cellInRange(sample)) begin
                    candNext  = sample;
                    stateNext = CHECK;
                end else if (retryLast) begin
                    failNext  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    retryNext = retryCnt + RETRY_W'(1);
                end
            end
            CHECK: begin
                if (chk_done) begin
                    if (chk_ok) begin
                        // Pulse is registered, so it lands in the COMMIT cycle
                        appleWeNext = (owner == OWN_APPLE);
                        obsWeNext   = (owner == OWN_OBS);
                        placeNext   = cand;
                        stateNext   = COMMIT;
                    end else if (retryLast) begin
                        failNext  = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        retryNext = retryCnt + RETRY_W'(1);
                        stateNext = GEN;
                    end
                end
            end
            COMMIT: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Soft reset overrides everything decided above
        if (s_reset) begin
            stateNext   = IDLE;
            retryNext   = '0;
            appleWeNext = 1'b0;
            obsWeNext   = 1'b0;
            failNext    = 1'b0;
            grantApple  = 1'b0;
            grantObs    = 1'b0;
        end

        // A request in the grant cycle re-queues because it wins over the clear
        applePendingNext = applePending;
        if (s_reset) begin
            applePendingNext = 1'b0;
        end else if (apple_req) begin
            applePendingNext = 1'b1;
        end else if (grantApple) begin
            applePendingNext = 1'b0;
        end

        // Simultaneous request and grant leave the count unchanged
        obsPendingNext = obs_pending;
        if (s_reset) begin
            obsPendingNext = '0;
        end else if (obs_req && !grantObs) begin
            if (obs_pending != PEND_W'(OBS_QUEUE_MAX)) begin
                obsPendingNext = obs_pending + PEND_W'(1);
            end
        end else if (!obs_req && grantObs) begin
            obsPendingNext = obs_pending - PEND_W'(1);
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            owner        <= OWN_APPLE;
            retryCnt     <= '0;
            applePending <= 1'b0;
            obs_pending  <= '0;
            cand         <= '0;
            place        <= '0;
            apple_we     <= 1'b0;
            obs_we       <= 1'b0;
            fail         <= 1'b0;
            busy         <= 1'b0;
            chk_valid    <= 1'b0;
        end else begin
            owner        <= ownerNext;
            retryCnt     <= retryNext;
            applePending <= applePendingNext;
            obs_pending  <= obsPendingNext;
            cand         <= candNext;
            place        <= placeNext;
            apple_we     <= appleWeNext;
            obs_we       <= obsWeNext;
            fail         <= failNext;
            busy         <= (stateNext != IDLE);
            chk_valid    <= (stateNext == CHECK);
        end
    end

    assign cand_x  = cand.x;
    assign cand_y  = cand.y;
    assign place_x = place.x;
    assign place_y = place.y;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Self-checking bench for spawn_scheduler. Commit and fail events are
// predicted from an LFSR reference model when requests are driven, queued,
// and matched against the DUT's write/fail pulses as they appear.
`timescale 1ns/1ps
module tb_spawn_scheduler;

    localparam int MAX_RETRIES = 15;
    localparam int OBS_MAX     = 3;
    localparam int K_APPLE     = 0;
    localparam int K_OBS       = 1;
    localparam int K_FAIL      = 2;
`ifdef SPAWN_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nRst = 1'b1;
    logic       s_reset = 1'b0;
    logic       apple_req = 1'b0;
    logic       obs_req = 1'b0;
    logic       chk_done = 1'b0;
    logic       chk_ok = 1'b0;
    logic       chk_valid;
    logic [3:0] cand_x;
    logic [3:0] cand_y;
    logic       apple_we;
    logic       obs_we;
    logic [3:0] place_x;
    logic [3:0] place_y;
    logic       busy;
    logic       fail;
    logic [2:0] obs_pending;
    logic [23:0] allOuts;

    spawn_scheduler #(
        .MAX_RETRIES   (MAX_RETRIES),
        .OBS_QUEUE_MAX (OBS_MAX),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .s_reset     (s_reset),
        .apple_req   (apple_req),
        .obs_req     (obs_req),
        .chk_valid   (chk_valid),
        .cand_x      (cand_x),
        .cand_y      (cand_y),
        .chk_done    (chk_done),
        .chk_ok      (chk_ok),
        .apple_we    (apple_we),
        .obs_we      (obs_we),
        .place_x     (place_x),
        .place_y     (place_y),
        .busy        (busy),
        .fail        (fail),
        .obs_pending (obs_pending)
    );

    assign allOuts = {chk_valid, cand_x, cand_y, apple_we, obs_we,
                      place_x, place_y, busy, fail, obs_pending};

    always #5 clk = ~clk;

    // Cycle index since reset release: value after edge n is n
    int cyc;
    always @(posedge clk or negedge nRst) begin
        if (!nRst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int kind;
        int x;
        int y;
        int at;
    } exp_t;

    exp_t sb[$];
    bit   lastObs = 1'b1;

    // Reference LFSR: value during cycle c after reset release
    function automatic logic [7:0] lfsrAt(input int c);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < c; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    function automatic bit fits(input logic [7:0] v);
        return (v[3:0] >= 1) && (v[3:0] <= 14) && (v[7:4] >= 1) && (v[7:4] <= 10);
    endfunction

    function automatic int firstFit(input int c);
        int k;
        k = c;
        for (int i = 0; i < MAX_RETRIES; i++) begin
            if (fits(lfsrAt(k))) return k;
            k++;
        end
        return k;
    endfunction

    function automatic bit appleFirst();
        return lastObs || !RR;
    endfunction

    // Grant in cycle grantCyc with an always-ok, zero-wait checker
    task automatic pushCommit(input int kind, input int grantCyc, output int nextIdle);
        int g;
        logic [7:0] v;
        exp_t e;
        g = firstFit(grantCyc + 1);
        v = lfsrAt(g);
        e.kind = kind; e.x = int'(v[3:0]); e.y = int'(v[7:4]); e.at = g + 2;
        sb.push_back(e);
        nextIdle = g + 3;
    endtask

    // Grant in cycle grantCyc with a checker that rejects every candidate
    task automatic pushFail(input int grantCyc);
        int c;
        int n;
        exp_t e;
        c = grantCyc + 1;
        n = 0;
        e.kind = K_FAIL; e.x = 0; e.y = 0;
        while (1) begin
            n++;
            if (fits(lfsrAt(c))) begin
                if (n == MAX_RETRIES) begin e.at = c + 2; break; end
                c += 2;
            end else begin
                if (n == MAX_RETRIES) begin e.at = c + 1; break; end
                c += 1;
            end
        end
        sb.push_back(e);
    endtask

    // Match every write/fail pulse against the scoreboard
    always @(negedge clk) begin
        int kind;
        exp_t e;
        if (nRst && (apple_we || obs_we || fail)) begin
            kind = fail ? K_FAIL : (obs_we ? K_OBS : K_APPLE);
            check("evt_onehot", int'(apple_we) + int'(obs_we) + int'(fail), 1);
            if (sb.size() == 0) begin
                check("unexpected_evt", kind, -1);
            end else begin
                e = sb.pop_front();
                check("evt_kind", kind, e.kind);
                check("evt_cycle", cyc, e.at);
                if (kind != K_FAIL) begin
                    check("place_x", int'(place_x), e.x);
                    check("place_y", int'(place_y), e.y);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goTo(input int c);
        while (cyc < c) tick();
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (((sb.size() != 0) || busy) && (n < budget)) begin
            tick();
            n++;
        end
        check("drain_queue", sb.size(), 0);
        check("drain_idle", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int g;
        int d;
        int nx;
        int first;
        logic [7:0] v;

        // Reset
        #1 nRst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", int'(allOuts), 0);
        #2 nRst = 1'b1;

        // Single apple, immediate accept
        chk_done = 1'b1;
        chk_ok   = 1'b1;
        goTo(2);
        apple_req = 1'b1;
        pushCommit(K_APPLE, 3, nx);
        lastObs = 1'b0;
        tick();
        apple_req = 1'b0;
        goTo(7);
        check("busy_c7", int'(busy), 0);
        waitDrain(50);

        // Simultaneous apple + obstacle pairs
        for (int p = 0; p < 2; p++) begin
            c0 = cyc;
            apple_req = 1'b1;
            obs_req   = 1'b1;
            tick();
            apple_req = 1'b0;
            obs_req   = 1'b0;
            check("pair_obs_pend", int'(obs_pending), 1);
            first = appleFirst() ? K_APPLE : K_OBS;
            pushCommit(first, c0 + 1, nx);
            pushCommit((first == K_APPLE) ? K_OBS : K_APPLE, nx, nx);
            lastObs = (first == K_APPLE);
            waitDrain(100);
            check("pair_obs_drain", int'(obs_pending), 0);
        end

        // Checker always rejects: one fail, no write
        chk_ok = 1'b0;
        c0 = cyc;
        obs_req = 1'b1;
        tick();
        obs_req = 1'b0;
        check("rej_obs_pend", int'(obs_pending), 1);
        pushFail(c0 + 1);
        lastObs = 1'b1;
        waitDrain(100);
        check("rej_obs_drain", int'(obs_pending), 0);

        // Stalled checker, obstacle queue saturation
        chk_done = 1'b0;
        chk_ok   = 1'b1;
        c0 = cyc;
        apple_req = 1'b1;
        tick();
        apple_req = 1'b0;
        g = firstFit(c0 + 2);
        v = lfsrAt(g);
        lastObs = 1'b0;
        for (int k = 0; k < 4; k++) begin
            obs_req = 1'b1;
            tick();
            obs_req = 1'b0;
            check("sat_obs_pend", int'(obs_pending), (k + 1 > OBS_MAX) ? OBS_MAX : k + 1);
            tick();
        end
        while (cyc < g + 11) begin
            if (cyc >= g + 1) begin
                check("stall_cand_x", int'(cand_x), int'(v[3:0]));
                check("stall_cand_y", int'(cand_y), int'(v[7:4]));
                check("stall_chk_valid", int'(chk_valid), 1);
            end
            tick();
        end
        d = cyc;
        chk_done = 1'b1;
        begin
            exp_t e;
            e.kind = K_APPLE; e.x = int'(v[3:0]); e.y = int'(v[7:4]); e.at = d + 1;
            sb.push_back(e);
        end
        nx = d + 2;
        for (int k = 0; k < OBS_MAX; k++) pushCommit(K_OBS, nx, nx);
        lastObs = 1'b1;
        waitDrain(200);
        check("sat_obs_drain", int'(obs_pending), 0);

        // Soft reset during CHECK with requests pending
        chk_done = 1'b0;
        c0 = cyc;
        apple_req = 1'b1;
        tick();
        apple_req = 1'b0;
        g = firstFit(c0 + 2);
        goTo(g + 2);
        apple_req = 1'b1;
        obs_req   = 1'b1;
        tick();
        apple_req = 1'b0;
        obs_req   = 1'b0;
        check("srst_pre_valid", int'(chk_valid), 1);
        check("srst_pre_obs", int'(obs_pending), 1);
        s_reset   = 1'b1;
        chk_done  = 1'b1;
        apple_req = 1'b1;
        obs_req   = 1'b1;
        tick();
        s_reset   = 1'b0;
        chk_done  = 1'b0;
        apple_req = 1'b0;
        obs_req   = 1'b0;
        check("srst_busy", int'(busy), 0);
        check("srst_valid", int'(chk_valid), 0);
        check("srst_obs", int'(obs_pending), 0);
        repeat (10) tick();
        check("srst_stay_idle", int'(busy), 0);

        // Asynchronous reset in the middle of GEN
        c0 = cyc;
        apple_req = 1'b1;
        tick();
        apple_req = 1'b0;
        goTo(c0 + 2);
        check("pre_nrst_busy", int'(busy), 1);
        #2 nRst = 1'b0;
        #1;
        check("nrst_outs", int'(allOuts), 0);
        check("nrst_lfsr", int'(dut.uLfsr.lfsr), 8'hA5);
        @(posedge clk);
        #3 nRst = 1'b1;
        lastObs = 1'b1;

        // Post-reset repeat of the first transaction
        chk_done = 1'b1;
        chk_ok   = 1'b1;
        goTo(2);
        apple_req = 1'b1;
        pushCommit(K_APPLE, 3, nx);
        lastObs = 1'b0;
        tick();
        apple_req = 1'b0;
        waitDrain(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
